// File: rtl/player_shot_ctrl.sv
// Player bullet controller: three bullet slots with a spawn cooldown, upward motion,
// registered pixel drawing, per-slot hit latching against the enemy and a dodge warning.

module player_shot_ctrl #(
    parameter int BULLET_W   = 4,
    parameter int BULLET_H   = 8,
    parameter int Y_SPEED    = 6,
    parameter int PLAYER_Y   = 440,
    parameter int PLAYER_W   = 30,
    parameter int COOLDOWN   = 10,
    parameter int DODGE_DIST = 60,
    parameter int ENEMY_W    = 30,
    parameter int ENEMY_H    = 30
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        fire,
    input  logic        pause,
    input  logic [10:0] playerX,
    input  logic [10:0] enemyTopLeftX,
    input  logic [10:0] enemyTopLeftY,
    input  logic        enemyDrawReq,
    output logic [2:0]  shotCollision,
    output logic        dodgeBullet,
    output logic        bulletDrawReq,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY
);

    localparam int SLOTS = 3;
    localparam int CD_W  = $clog2(COOLDOWN + 2);

    localparam logic [10:0]          SPAWN_Y  = 11'(PLAYER_Y - BULLET_H);
    localparam logic [10:0]          CENTER_X = 11'((PLAYER_W - BULLET_W) / 2);
    localparam logic [10:0]          STEP_Y   = 11'(Y_SPEED);
    localparam logic [11:0]          BW       = 12'(BULLET_W);
    localparam logic [11:0]          BH       = 12'(BULLET_H);
    localparam logic [11:0]          EW       = 12'(ENEMY_W);
    localparam logic signed [12:0]   EH       = 13'(ENEMY_H);
    localparam logic signed [12:0]   DD       = 13'(DODGE_DIST);
    localparam logic [CD_W-1:0]      CD_LOAD  = CD_W'(COOLDOWN);
    localparam logic [CD_W-1:0]      CD_ONE   = CD_W'(1);

    logic [SLOTS-1:0]      active;
    logic [SLOTS-1:0]      hit;
    logic [SLOTS-1:0]      match;
    logic [SLOTS-1:0]      match_q;
    logic [SLOTS-1:0]      threat;
    logic [10:0]           slot_x [SLOTS];
    logic [10:0]           slot_y [SLOTS];
    logic signed [12:0]    below  [SLOTS];
    logic                  fire_q;
    logic                  fire_rise;
    logic                  pending;
    logic [CD_W-1:0]       cooldown;
    logic [10:0]           off_x;
    logic [10:0]           off_y;
    logic [1:0]            spawn_idx;
    logic                  have_free;
    logic                  spawn_ok;

    assign fire_rise = fire & ~fire_q;

    // Scanning downward leaves the lowest-index matching slot as the offset source.
    always_comb begin
        match = '0;
        off_x = '0;
        off_y = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            match[i] = active[i]
                && ({1'b0, pixelX} >= {1'b0, slot_x[i]})
                && ({1'b0, pixelX} <  ({1'b0, slot_x[i]} + BW))
                && ({1'b0, pixelY} >= {1'b0, slot_y[i]})
                && ({1'b0, pixelY} <  ({1'b0, slot_y[i]} + BH));
            if (match[i]) begin
                off_x = pixelX - slot_x[i];
                off_y = pixelY - slot_y[i];
            end
        end
    end

    // A slot threatens the enemy when it is horizontally aligned and within the band below it.
    always_comb begin
        threat = '0;
        for (int i = 0; i < SLOTS; i++) begin
            below[i] = $signed({2'b00, slot_y[i]}) - $signed({2'b00, enemyTopLeftY}) - EH;
            threat[i] = active[i] && !hit[i]
                && ({1'b0, slot_x[i]} < ({1'b0, enemyTopLeftX} + EW))
                && ({1'b0, enemyTopLeftX} < ({1'b0, slot_x[i]} + BW))
                && !below[i][12]
                && (below[i] <= DD);
        end
    end

    // Spawn slot is picked from the flags as they stand before this tick's updates.
    always_comb begin
        spawn_idx = '0;
        have_free = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                spawn_idx = 2'(i);
                have_free = 1'b1;
            end
        end
        spawn_ok = pending && !pause && have_free && (cooldown <= CD_ONE);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            active        <= '0;
            hit           <= '0;
            match_q       <= '0;
            fire_q        <= 1'b0;
            pending       <= 1'b0;
            cooldown      <= '0;
            shotCollision <= '0;
            dodgeBullet   <= 1'b0;
            bulletDrawReq <= 1'b0;
            offsetX       <= '0;
            offsetY       <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            fire_q        <= fire;
            match_q       <= match;
            bulletDrawReq <= |match;
            offsetX       <= off_x;
            offsetY       <= off_y;

            if (startOfFrame) begin
                shotCollision <= hit;
                dodgeBullet   <= |threat;
                hit           <= '0;

                // Hits remove a slot even while paused and win over motion and off-screen removal.
                for (int i = 0; i < SLOTS; i++) begin
                    if (hit[i]) begin
                        active[i] <= 1'b0;
                    end else if (active[i] && !pause) begin
                        if (slot_y[i] < STEP_Y) begin
                            active[i] <= 1'b0;
                        end else begin
                            slot_y[i] <= slot_y[i] - STEP_Y;
                        end
                    end
                end

                if (!pause) begin
                    if (spawn_ok) begin
                        active[spawn_idx] <= 1'b1;
                        slot_x[spawn_idx] <= playerX + CENTER_X;
                        slot_y[spawn_idx] <= SPAWN_Y;
                        cooldown          <= CD_LOAD;
                    end else if (cooldown != '0) begin
                        cooldown <= cooldown - CD_ONE;
                    end
                    pending <= fire_rise;
                end else if (fire_rise) begin
                    pending <= 1'b1;
                end
            end else begin
                shotCollision <= '0;
                dodgeBullet   <= 1'b0;
                hit           <= hit | (match_q & active & {SLOTS{enemyDrawReq}});
                if (fire_rise) begin
                    pending <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_player_shot_ctrl.sv
// Bench for player_shot_ctrl: directed vector table, hand-written multi-cycle sequences
// and a randomized run against a slot-level reference model (two parameter sets).

module tb_player_shot_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        startOfFrame = 1'b0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic        fire = 1'b0;
    logic        pause = 1'b0;
    logic [10:0] playerX = '0;
    logic [10:0] enemyTopLeftX = '0;
    logic [10:0] enemyTopLeftY = '0;
    logic        enemyDrawReq = 1'b0;

    logic [2:0]  a_col, b_col;
    logic        a_dodge, b_dodge, a_draw, b_draw;
    logic [10:0] a_ox, a_oy, b_ox, b_oy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    player_shot_ctrl dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .fire(fire), .pause(pause),
        .playerX(playerX), .enemyTopLeftX(enemyTopLeftX), .enemyTopLeftY(enemyTopLeftY),
        .enemyDrawReq(enemyDrawReq), .shotCollision(a_col), .dodgeBullet(a_dodge),
        .bulletDrawReq(a_draw), .offsetX(a_ox), .offsetY(a_oy)
    );

    player_shot_ctrl #(.COOLDOWN(0), .PLAYER_Y(444)) dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .pixelX(pixelX), .pixelY(pixelY), .fire(fire), .pause(pause),
        .playerX(playerX), .enemyTopLeftX(enemyTopLeftX), .enemyTopLeftY(enemyTopLeftY),
        .enemyDrawReq(enemyDrawReq), .shotCollision(b_col), .dodgeBullet(b_dodge),
        .bulletDrawReq(b_draw), .offsetX(b_ox), .offsetY(b_oy)
    );

    typedef struct {
        bit sof;
        bit fr;
        bit edr;
        int px;
        int py;
        bit e_draw;
        int e_ox;
        int e_oy;
        int e_col;
        bit e_dodge;
    } vec_t;

    // Reference model state: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int cool_cfg [2]    = '{10, 0};
    int spawn_y_cfg [2] = '{432, 436};
    bit m_act [2][3];
    int m_x [2][3];
    int m_y [2][3];
    bit m_hit [2][3];
    bit m_mq [2][3];
    bit m_pend [2];
    int m_cd [2];
    bit m_fq;
    int e_draw [2], e_ox [2], e_oy [2], e_col [2], e_dodge [2];

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input bit sof, input bit fr, input bit ps, input bit edr,
                                  input int px, input int py);
        startOfFrame = sof;
        fire         = fr;
        pause        = ps;
        enemyDrawReq = edr;
        pixelX       = 11'(px);
        pixelY       = 11'(py);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        startOfFrame = 1'b0;
        fire = 1'b0;
        pause = 1'b0;
        enemyDrawReq = 1'b0;
        pixelX = '0;
        pixelY = '0;
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 3; i++) begin
                m_act[d][i] = 0; m_x[d][i] = 0; m_y[d][i] = 0;
                m_hit[d][i] = 0; m_mq[d][i] = 0;
            end
            m_pend[d] = 0;
            m_cd[d] = 0;
        end
        m_fq = 0;
    endtask

    // Advances the model across one clock edge using the inputs currently applied.
    task automatic model_step();
        bit rise;
        int px, py, ex, ey;
        rise = fire && !m_fq;
        px = int'(pixelX); py = int'(pixelY);
        ex = int'(enemyTopLeftX); ey = int'(enemyTopLeftY);
        for (int d = 0; d < 2; d++) begin
            bit cur [3];
            bit found;
            int free_slot;
            int dy;
            found = 0;
            e_draw[d] = 0; e_ox[d] = 0; e_oy[d] = 0;
            for (int i = 0; i < 3; i++) begin
                cur[i] = m_act[d][i] && px >= m_x[d][i] && px < m_x[d][i] + 4
                         && py >= m_y[d][i] && py < m_y[d][i] + 8;
                if (cur[i] && !found) begin
                    found = 1;
                    e_draw[d] = 1;
                    e_ox[d] = px - m_x[d][i];
                    e_oy[d] = py - m_y[d][i];
                end
            end
            if (startOfFrame) begin
                e_col[d] = 0; e_dodge[d] = 0; free_slot = -1;
                for (int i = 0; i < 3; i++) begin
                    dy = m_y[d][i] - (ey + 30);
                    if (m_hit[d][i]) e_col[d] += (1 << i);
                    else if (m_act[d][i] && m_x[d][i] < ex + 30 && ex < m_x[d][i] + 4
                             && dy >= 0 && dy <= 60) e_dodge[d] = 1;
                    if (!m_act[d][i] && free_slot < 0) free_slot = i;
                end
                for (int i = 0; i < 3; i++) begin
                    if (m_hit[d][i]) m_act[d][i] = 0;
                    else if (m_act[d][i] && !pause) begin
                        if (m_y[d][i] < 6) m_act[d][i] = 0;
                        else m_y[d][i] -= 6;
                    end
                end
                if (!pause) begin
                    if (m_pend[d] && m_cd[d] <= 1 && free_slot >= 0) begin
                        m_act[d][free_slot] = 1;
                        m_x[d][free_slot] = (int'(playerX) + 13) % 2048;
                        m_y[d][free_slot] = spawn_y_cfg[d];
                        m_cd[d] = cool_cfg[d];
                    end else if (m_cd[d] > 0) begin
                        m_cd[d]--;
                    end
                    m_pend[d] = rise;
                end else if (rise) begin
                    m_pend[d] = 1;
                end
                for (int i = 0; i < 3; i++) m_hit[d][i] = 0;
            end else begin
                e_col[d] = 0; e_dodge[d] = 0;
                for (int i = 0; i < 3; i++)
                    if (m_mq[d][i] && enemyDrawReq && m_act[d][i]) m_hit[d][i] = 1;
                if (rise) m_pend[d] = 1;
            end
            for (int i = 0; i < 3; i++) m_mq[d][i] = cur[i];
        end
        m_fq = fire;
    endtask

    function automatic logic [10:0] clamp11(input int v);
        if (v < 0) return 11'd0;
        if (v > 2047) return 11'd2047;
        return 11'(v);
    endfunction

    initial begin
        vec_t tbl [14];
        int k;

        // Reset values while held in reset.
        #1 resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset.col", a_col, 0);
        check_output("reset.dodge", a_dodge, 0);
        check_output("reset.draw", a_draw, 0);
        check_output("reset.ox", a_ox, 0);
        check_output("reset.oy", a_oy, 0);
        check_output("reset.b_draw", b_draw, 0);
        resetN = 1'b1;

        // Spawn, motion, drawing bounds and a hit on slot 0 (dut_a).
        playerX = 11'd100; enemyTopLeftX = 11'd111; enemyTopLeftY = 11'd0;
        tbl[0]  = '{0, 1, 0,   0,   0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,   0,   0, 0, 0, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 113, 432, 1, 0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 116, 439, 1, 3, 7, 0, 0};
        tbl[4]  = '{0, 0, 0, 117, 432, 0, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, 0, 113, 431, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 0, 0,   0,   0, 0, 0, 0, 0, 0};
        tbl[7]  = '{0, 0, 0, 113, 426, 1, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, 0, 114, 433, 1, 1, 7, 0, 0};
        tbl[9]  = '{0, 0, 1,   0,   0, 0, 0, 0, 0, 0};
        tbl[10] = '{1, 0, 0,   0,   0, 0, 0, 0, 1, 0};
        tbl[11] = '{0, 0, 0,   0,   0, 0, 0, 0, 0, 0};
        tbl[12] = '{0, 0, 0, 113, 420, 0, 0, 0, 0, 0};
        tbl[13] = '{0, 0, 0, 113, 426, 0, 0, 0, 0, 0};
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(tbl[i].sof, tbl[i].fr, 1'b0, tbl[i].edr, tbl[i].px, tbl[i].py);
            check_output($sformatf("tbl%0d.draw", i), a_draw, tbl[i].e_draw);
            check_output($sformatf("tbl%0d.ox", i), a_ox, tbl[i].e_ox);
            check_output($sformatf("tbl%0d.oy", i), a_oy, tbl[i].e_oy);
            check_output($sformatf("tbl%0d.col", i), a_col, tbl[i].e_col);
            check_output($sformatf("tbl%0d.dodge", i), a_dodge, tbl[i].e_dodge);
        end

        // Four shots one frame apart: three slots fill on dut_b, the fourth is dropped.
        do_reset();
        enemyTopLeftX = 11'd600;
        for (int s = 0; s < 4; s++) begin
            playerX = 11'(100 + 20 * s);
            apply_stimulus(0, 1, 0, 0, 0, 0);
            apply_stimulus(0, 0, 0, 0, 0, 0);
            apply_stimulus(1, 0, 0, 0, 0, 0);
        end
        apply_stimulus(0, 0, 0, 0, 113, 418); check_output("full.b_slot0", b_draw, 1);
        apply_stimulus(0, 0, 0, 0, 133, 424); check_output("full.b_slot1", b_draw, 1);
        apply_stimulus(0, 0, 0, 0, 153, 430); check_output("full.b_slot2", b_draw, 1);
        apply_stimulus(0, 0, 0, 0, 173, 436); check_output("full.b_fourth", b_draw, 0);
        apply_stimulus(0, 0, 0, 0, 113, 414); check_output("full.a_first", a_draw, 1);
        apply_stimulus(0, 0, 0, 0, 133, 420); check_output("full.a_cooled", a_draw, 0);

        // Firing every frame on dut_a spawns exactly every ten frames.
        do_reset();
        playerX = 11'd100;
        for (int f = 0; f < 25; f++) begin
            apply_stimulus(0, 1, 0, 0, 0, 0);
            apply_stimulus(0, 0, 0, 0, 0, 0);
            apply_stimulus(1, 0, 0, 0, 0, 0);
            apply_stimulus(0, 0, 0, 0, 113, 439);
            check_output($sformatf("cool.f%0d", f), a_draw, (f % 10 == 0) ? 1 : 0);
        end

        // Dodge band and horizontal boundaries with the bullet frozen at (110,360).
        do_reset();
        playerX = 11'd97; enemyTopLeftX = 11'd600; enemyTopLeftY = 11'd0;
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 12; f++) apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 110, 360); check_output("dodge.at360", a_draw, 1);
        apply_stimulus(0, 0, 0, 0, 110, 359); check_output("dodge.above", a_draw, 0);
        begin
            int cases [9][3] = '{'{100, 300, 1}, '{100, 269, 0}, '{100, 270, 1},
                                 '{100, 330, 1}, '{100, 331, 0}, '{114, 300, 0},
                                 '{113, 300, 1}, '{81, 300, 1}, '{80, 300, 0}};
            for (int c = 0; c < 9; c++) begin
                enemyTopLeftX = 11'(cases[c][0]);
                enemyTopLeftY = 11'(cases[c][1]);
                apply_stimulus(1, 0, 1, 0, 0, 0);
                check_output($sformatf("dodge.case%0d", c), a_dodge, cases[c][2]);
            end
        end
        apply_stimulus(0, 0, 1, 0, 0, 0); check_output("dodge.one_cycle", a_dodge, 0);
        apply_stimulus(0, 0, 1, 0, 110, 360); check_output("pause.frozen", a_draw, 1);
        apply_stimulus(0, 0, 1, 0, 111, 361);
        apply_stimulus(0, 0, 1, 1, 0, 0);
        enemyTopLeftX = 11'd100; enemyTopLeftY = 11'd300;
        apply_stimulus(1, 0, 1, 0, 0, 0);
        check_output("pausehit.col", a_col, 1);
        check_output("pausehit.no_dodge", a_dodge, 0);
        apply_stimulus(0, 0, 1, 0, 0, 0); check_output("pausehit.pulse", a_col, 0);
        apply_stimulus(0, 0, 0, 0, 110, 360); check_output("pausehit.gone", a_draw, 0);

        // Off-screen removal without wrap on dut_b (spawn row 436 reaches row 4).
        do_reset();
        playerX = 11'd100; enemyTopLeftX = 11'd600;
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 72; f++) apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 113, 4); check_output("edge.at4", b_draw, 1);
        check_output("edge.oy", b_oy, 0);
        apply_stimulus(0, 0, 0, 0, 113, 3); check_output("edge.above4", b_draw, 0);
        for (int f = 0; f < 3; f++) apply_stimulus(1, 0, 1, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 113, 4); check_output("edge.paused", b_draw, 1);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 113, 4); check_output("edge.removed", b_draw, 0);
        apply_stimulus(0, 0, 0, 0, 113, 2046); check_output("edge.no_wrap", b_draw, 0);
        apply_stimulus(0, 0, 0, 0, 113, 0); check_output("edge.row0", b_draw, 0);

        // Reset mid-flight with a latched hit: no pulse afterwards, bullets gone.
        do_reset();
        playerX = 11'd100;
        apply_stimulus(0, 1, 0, 0, 0, 0);
        apply_stimulus(1, 0, 0, 0, 0, 0);
        apply_stimulus(0, 0, 0, 0, 113, 433);
        apply_stimulus(0, 0, 0, 1, 113, 433);
        check_output("midrst.before", a_draw, 1);
        #2 resetN = 1'b0;
        #1;
        check_output("midrst.draw", a_draw, 0);
        check_output("midrst.oy", a_oy, 0);
        check_output("midrst.b_draw", b_draw, 0);
        enemyDrawReq = 1'b0; pixelX = '0; pixelY = '0;
        @(posedge clk);
        #1 resetN = 1'b1;
        apply_stimulus(1, 0, 0, 0, 0, 0);
        check_output("midrst.col", a_col, 0);
        apply_stimulus(0, 0, 0, 0, 113, 433); check_output("midrst.gone", a_draw, 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int f = 0; f < 160; f++) begin
            playerX = 11'($urandom_range(0, 600));
            pause = ($urandom_range(0, 5) == 0);
            k = $urandom_range(0, 2);
            if (m_act[0][k] && $urandom_range(0, 1) == 1) begin
                enemyTopLeftX = clamp11(m_x[0][k] - int'($urandom_range(0, 33)));
                enemyTopLeftY = clamp11(m_y[0][k] - 30 - int'($urandom_range(0, 64)));
            end else begin
                enemyTopLeftX = 11'($urandom_range(0, 610));
                enemyTopLeftY = 11'($urandom_range(0, 450));
            end
            for (int c = 0; c < 7; c++) begin
                startOfFrame = (c == 0);
                if ($urandom_range(0, 2) == 0) fire = ~fire;
                enemyDrawReq = ($urandom_range(0, 3) == 0);
                k = $urandom_range(0, 2);
                if (m_act[0][k] && $urandom_range(0, 2) != 0) begin
                    pixelX = clamp11(m_x[0][k] + int'($urandom_range(0, 5)) - 1);
                    pixelY = clamp11(m_y[0][k] + int'($urandom_range(0, 9)) - 1);
                end else begin
                    pixelX = 11'($urandom_range(0, 639));
                    pixelY = 11'($urandom_range(0, 479));
                end
                model_step();
                @(posedge clk);
                #1;
                check_output("rnd.a.draw", a_draw, e_draw[0]);
                check_output("rnd.a.ox", a_ox, e_ox[0]);
                check_output("rnd.a.oy", a_oy, e_oy[0]);
                check_output("rnd.a.col", a_col, e_col[0]);
                check_output("rnd.a.dodge", a_dodge, e_dodge[0]);
                check_output("rnd.b.draw", b_draw, e_draw[1]);
                check_output("rnd.b.ox", b_ox, e_ox[1]);
                check_output("rnd.b.oy", b_oy, e_oy[1]);
                check_output("rnd.b.col", b_col, e_col[1]);
                check_output("rnd.b.dodge", b_dodge, e_dodge[1]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
